// File: rtl/fifo_wptr_full_pkg.sv
// Shared definitions for the async FIFO pointer logic: Gray conversions and depth.
package fifo_wptr_full_pkg;

    localparam int unsigned FIFO_ABITS = 10;
    localparam int unsigned FIFO_DEPTH = 2 ** FIFO_ABITS;

    // Binary to Gray; zero-extended inputs of any width up to 32 bits convert correctly.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary via prefix XOR; zero-extended inputs of any width up to 32 bits.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        b = b ^ (b >> 8);
        b = b ^ (b >> 16);
        return b;
    endfunction

endpackage

// File: rtl/fifo_sync2.sv
// Two-flop synchronizer for multi-bit Gray-coded pointers crossing clock domains.
module fifo_sync2 #(
    parameter int unsigned W = 11
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q1;

    // Two-stage capture; only the second stage is consumed downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and full-flag controller for the asynchronous FIFO.
// Define FIFO_WPTR_ALMOST_FULL_EN to build the almost_full / w_level status logic;
// otherwise those outputs are tied to 0.
module fifo_wptr_full
    import fifo_wptr_full_pkg::*;
#(
    parameter int unsigned ABITS     = FIFO_ABITS,
    parameter int unsigned AF_THRESH = 4
) (
    input  logic             wclk,
    input  logic             rst,
    input  logic             w_en,
    input  logic [ABITS:0]   r_gray_ptr,
    output logic [ABITS-1:0] w_bin_ptr,
    output logic             w_allow,
    output logic [ABITS:0]   w_gray_ptr,
    output logic             full,
    output logic             w_ovf,
    output logic             almost_full,
    output logic [ABITS:0]   w_level
);

    localparam int unsigned PW    = ABITS + 1;
    localparam int unsigned DEPTH = 2 ** ABITS;
    // Full when the write Gray pointer equals the read Gray pointer with its top two bits flipped.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);

    // Reject a threshold outside 1 .. DEPTH-1 at elaboration.
    if (AF_THRESH == 0 || AF_THRESH >= DEPTH) begin : g_bad_thresh
        $error("fifo_wptr_full: AF_THRESH out of range");
    end

    logic [PW-1:0] w_bin;
    logic [PW-1:0] rq2;
    logic [PW-1:0] w_bin_next_c;
    logic [PW-1:0] w_gray_next_c;
    logic          full_next_c;

    fifo_sync2 #(.W(PW)) u_rptr_sync (
        .clk (wclk),
        .rst (rst),
        .d   (r_gray_ptr),
        .q   (rq2)
    );

    assign w_allow   = w_en & ~full;
    assign w_bin_ptr = w_bin[ABITS-1:0];

    // Next pointer values and the full comparison against the synchronized read pointer.
    always_comb begin
        w_bin_next_c  = w_bin + PW'(w_allow);
        w_gray_next_c = PW'(bin2gray(32'(w_bin_next_c)));
        full_next_c   = (w_gray_next_c == (rq2 ^ FULL_MASK));
    end

    // Pointer and flag registers; a refused write only raises the overflow pulse.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            w_bin      <= '0;
            w_gray_ptr <= '0;
            full       <= 1'b0;
            w_ovf      <= 1'b0;
        end else begin
            w_bin      <= w_bin_next_c;
            w_gray_ptr <= w_gray_next_c;
            full       <= full_next_c;
            w_ovf      <= w_en & full;
        end
    end

`ifdef FIFO_WPTR_ALMOST_FULL_EN
    logic [PW-1:0] rbin_c;
    logic [PW-1:0] level_next_c;
    logic          af_next_c;

    // Fill level as seen from the write side, using the lagging read pointer.
    always_comb begin
        rbin_c       = PW'(gray2bin(32'(rq2)));
        level_next_c = w_bin_next_c - rbin_c;
        af_next_c    = (level_next_c >= PW'(DEPTH - AF_THRESH));
    end

    // Status registers for fill level and almost-full.
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            w_level     <= '0;
            almost_full <= 1'b0;
        end else begin
            w_level     <= level_next_c;
            almost_full <= af_next_c;
        end
    end
`else
    assign w_level     = '0;
    assign almost_full = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Directed bench for fifo_wptr_full at ABITS=2 (depth 4), AF_THRESH=1.
module tb_fifo_wptr_full;

    localparam int unsigned ABITS = 2;
    localparam int unsigned PW    = ABITS + 1;

    logic             wclk = 1'b0;
    logic             rst  = 1'b1;
    logic             w_en = 1'b0;
    logic [PW-1:0]    r_gray_ptr = '0;
    logic [ABITS-1:0] w_bin_ptr;
    logic             w_allow;
    logic [PW-1:0]    w_gray_ptr;
    logic             full;
    logic             w_ovf;
    logic             almost_full;
    logic [PW-1:0]    w_level;

    int errors = 0;
    int checks = 0;

    fifo_wptr_full #(.ABITS(ABITS), .AF_THRESH(1)) dut (
        .wclk        (wclk),
        .rst         (rst),
        .w_en        (w_en),
        .r_gray_ptr  (r_gray_ptr),
        .w_bin_ptr   (w_bin_ptr),
        .w_allow     (w_allow),
        .w_gray_ptr  (w_gray_ptr),
        .full        (full),
        .w_ovf       (w_ovf),
        .almost_full (almost_full),
        .w_level     (w_level)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic          w_en;
        logic [PW-1:0] r_gray;
        logic          e_allow;
        logic [1:0]    e_ptr;
        logic [PW-1:0] e_gray;
        logic          e_full;
        logic          e_ovf;
        logic          e_af;
        logic [PW-1:0] e_level;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Status outputs are only built with the almost-full option.
    function automatic logic [31:0] st(input logic [31:0] v);
`ifdef FIFO_WPTR_ALMOST_FULL_EN
        return v;
`else
        return 32'(v & 32'h0);
`endif
    endfunction

    function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic do_reset();
        @(negedge wclk);
        rst = 1'b1;
        w_en = 1'b0;
        r_gray_ptr = '0;
        @(negedge wclk);
        rst = 1'b0;
    endtask

    logic [PW-1:0] prev_gray;
    logic [PW-1:0] diff;
    logic [PW-1:0] wcnt;
    logic          saw_wrap;

    initial begin
        vecs[0] = '{1'b1, 3'b000, 1'b1, 2'd1, 3'b001, 1'b0, 1'b0, 1'b0, 3'd1};
        vecs[1] = '{1'b1, 3'b000, 1'b1, 2'd2, 3'b011, 1'b0, 1'b0, 1'b0, 3'd2};
        vecs[2] = '{1'b1, 3'b000, 1'b1, 2'd3, 3'b010, 1'b0, 1'b0, 1'b1, 3'd3};
        vecs[3] = '{1'b1, 3'b000, 1'b1, 2'd0, 3'b110, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[4] = '{1'b1, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b1, 1'b1, 3'd4};
        vecs[5] = '{1'b0, 3'b000, 1'b0, 2'd0, 3'b110, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[6] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[7] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b1, 1'b0, 1'b1, 3'd4};
        vecs[8] = '{1'b0, 3'b001, 1'b0, 2'd0, 3'b110, 1'b0, 1'b0, 1'b1, 3'd3};
        vecs[9] = '{1'b1, 3'b001, 1'b1, 2'd1, 3'b111, 1'b1, 1'b0, 1'b1, 3'd4};

        // Reset held with a pending write request.
        w_en = 1'b1;
        repeat (2) @(posedge wclk);
        #1;
        check("rst_ptr", 32'(w_bin_ptr), 32'd0);
        check("rst_gray", 32'(w_gray_ptr), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(w_ovf), 32'd0);
        check("rst_af", 32'(almost_full), 32'd0);
        check("rst_level", 32'(w_level), 32'd0);
        check("rst_allow", 32'(w_allow), 32'd1);

        // First edge after release writes address 0.
        @(negedge wclk);
        rst = 1'b0;
        #1;
        check("first_addr", 32'(w_bin_ptr), 32'd0);
        @(posedge wclk);
        #1;
        check("first_gray", 32'(w_gray_ptr), 32'b001);

        // Fill, overflow, drain latency, and refill from a clean start.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            w_en = vecs[i].w_en;
            r_gray_ptr = vecs[i].r_gray;
            #1;
            check($sformatf("v%0d_allow", i), 32'(w_allow), 32'(vecs[i].e_allow));
            @(posedge wclk);
            #1;
            check($sformatf("v%0d_ptr", i), 32'(w_bin_ptr), 32'(vecs[i].e_ptr));
            check($sformatf("v%0d_gray", i), 32'(w_gray_ptr), 32'(vecs[i].e_gray));
            check($sformatf("v%0d_full", i), 32'(full), 32'(vecs[i].e_full));
            check($sformatf("v%0d_ovf", i), 32'(w_ovf), 32'(vecs[i].e_ovf));
            check($sformatf("v%0d_af", i), 32'(almost_full), st(32'(vecs[i].e_af)));
            check($sformatf("v%0d_level", i), 32'(w_level), st(32'(vecs[i].e_level)));
            @(negedge wclk);
        end

        // Continuous stream of 20 writes with the read pointer trailing the write count.
        do_reset();
        wcnt = '0;
        prev_gray = '0;
        saw_wrap = 1'b0;
        for (int i = 0; i < 20; i++) begin
            w_en = 1'b1;
            #1;
            check($sformatf("wrap%0d_allow", i), 32'(w_allow), 32'd1);
            @(posedge wclk);
            #1;
            wcnt = wcnt + 3'd1;
            if (wcnt == 3'd0) saw_wrap = 1'b1;
            diff = w_gray_ptr ^ prev_gray;
            check($sformatf("wrap%0d_onebit", i), 32'($countones(diff)), 32'd1);
            check($sformatf("wrap%0d_gray", i), 32'(w_gray_ptr), 32'(gray(wcnt)));
            check($sformatf("wrap%0d_ptr", i), 32'(w_bin_ptr), 32'(wcnt[1:0]));
            check($sformatf("wrap%0d_full", i), 32'(full), 32'd0);
            prev_gray = w_gray_ptr;
            @(negedge wclk);
            r_gray_ptr = gray(wcnt);
        end
        check("wrap_seen", 32'(saw_wrap), 32'd1);

        // Asynchronous reset between edges at level 3.
        do_reset();
        w_en = 1'b1;
        repeat (3) @(posedge wclk);
        @(negedge wclk);
        w_en = 1'b0;
        #1;
        check("pre_rst_ptr", 32'(w_bin_ptr), 32'd3);
        check("pre_rst_level", 32'(w_level), st(32'd3));
        #2;
        rst = 1'b1;
        #1;
        check("async_ptr", 32'(w_bin_ptr), 32'd0);
        check("async_gray", 32'(w_gray_ptr), 32'd0);
        check("async_af", 32'(almost_full), 32'd0);
        check("async_level", 32'(w_level), 32'd0);
        check("async_full", 32'(full), 32'd0);
        @(negedge wclk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
